// File: rtl/fir_xifu_wb_ctrl_if.sv
// EX / memory-result / XIF-result / FIR-regfile signal bundle for the FIR XIFU writeback controller.
// master = surrounding pipeline, slave = fir_xifu_wb_ctrl.
interface fir_xifu_wb_ctrl_if #(
    parameter int DEPTH = 4,
    parameter int ID_W  = 4,
    parameter int RD_W  = 2
);
    logic            ex_valid_i;
    logic            ex_ready_o;
    logic [1:0]      ex_instr_i;
    logic [ID_W-1:0] ex_id_i;
    logic [RD_W-1:0] ex_rd_i;
    logic [4:0]      ex_rs1_i;
    logic [31:0]     ex_result_i;

    logic            mem_result_valid_i;
    logic [ID_W-1:0] mem_result_id_i;
    logic [31:0]     mem_result_rdata_i;

    logic            result_valid_o;
    logic            result_ready_i;
    logic [ID_W-1:0] result_id_o;
    logic [31:0]     result_data_o;
    logic [4:0]      result_rd_o;
    logic            result_we_o;

    logic            rf_we_o;
    logic [RD_W-1:0] rf_waddr_o;
    logic [31:0]     rf_wdata_o;

    modport master (
        output ex_valid_i, ex_instr_i, ex_id_i, ex_rd_i, ex_rs1_i, ex_result_i,
        output mem_result_valid_i, mem_result_id_i, mem_result_rdata_i,
        output result_ready_i,
        input  ex_ready_o, result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o,
        input  rf_we_o, rf_waddr_o, rf_wdata_o
    );

    modport slave (
        input  ex_valid_i, ex_instr_i, ex_id_i, ex_rd_i, ex_rs1_i, ex_result_i,
        input  mem_result_valid_i, mem_result_id_i, mem_result_rdata_i,
        input  result_ready_i,
        output ex_ready_o, result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o,
        output rf_we_o, rf_waddr_o, rf_wdata_o
    );
endinterface

// File: rtl/fir_xifu_wb_ctrl.sv
// In-order writeback scheduler for the FIR XIFU: FIFO of issued entries, head FSM, regfile port and XIF result.
// Optional macro FIR_XIFU_WB_BYPASS_EN: a matching mem result with result_ready_i=1 is returned in the same cycle.
module fir_xifu_wb_ctrl #(
    parameter int DEPTH = 4,
    parameter int ID_W  = 4,
    parameter int RD_W  = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    fir_xifu_wb_ctrl_if.slave      bus,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   err_o
);
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [1:0] I_DOTP = 2'd0;
    localparam logic [1:0] I_LW   = 2'd1;
    localparam logic [1:0] I_SW   = 2'd2;
    localparam logic [1:0] I_NONE = 2'd3;

    typedef struct packed {
        logic [1:0]      instr;
        logic [ID_W-1:0] id;
        logic [RD_W-1:0] rd;
        logic [4:0]      rs1;
        logic [31:0]     result;
    } entry_t;

    typedef enum logic [1:0] {IDLE, WAIT_MEM, RESULT} state_e;

    entry_t          fifo_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]  count_q;
    state_e          state_q;
    logic            err_q;

    logic            res_valid_q;
    logic [ID_W-1:0] res_id_q;
    logic [31:0]     res_data_q;
    logic [4:0]      res_rd_q;

    entry_t head;
    logic   not_empty, ex_ready, push, pop;
    logic   mem_match, dotp_wr, lw_wr, rf_we, bypass;

    assign head      = fifo_q[rd_ptr_q];
    assign not_empty = (count_q != '0);
    assign ex_ready  = (count_q < (PTR_W+1)'(DEPTH));
    assign push      = bus.ex_valid_i && ex_ready;

    assign mem_match = bus.mem_result_valid_i && (state_q == WAIT_MEM) &&
                       (bus.mem_result_id_i == head.id);
    assign dotp_wr   = (state_q == IDLE) && not_empty && (head.instr == I_DOTP);
    assign lw_wr     = mem_match && (head.instr == I_LW);
    assign rf_we     = dotp_wr || lw_wr;

`ifdef FIR_XIFU_WB_BYPASS_EN
    assign bypass = mem_match && bus.result_ready_i;
`else
    assign bypass = 1'b0;
`endif

    // DOTP and NONE leave after exactly one cycle at head; memory ops leave on result handshake.
    assign pop = ((state_q == IDLE) && not_empty && ((head.instr == I_DOTP) || (head.instr == I_NONE))) ||
                 bypass || (res_valid_q && bus.result_ready_i);

    assign bus.ex_ready_o     = ex_ready;
    assign bus.rf_we_o        = rf_we;
    assign bus.rf_waddr_o     = rf_we ? head.rd : '0;
    assign bus.rf_wdata_o     = dotp_wr ? head.result : (lw_wr ? bus.mem_result_rdata_i : '0);

    assign bus.result_valid_o = res_valid_q || bypass;
    assign bus.result_id_o    = bypass ? head.id     : res_id_q;
    assign bus.result_data_o  = bypass ? head.result : res_data_q;
    assign bus.result_rd_o    = bypass ? head.rs1    : res_rd_q;
    assign bus.result_we_o    = res_valid_q || bypass;

    assign count_o = count_q;
    assign err_o   = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= IDLE;
            err_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_data_q  <= '0;
            res_rd_q    <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= '{instr: bus.ex_instr_i, id: bus.ex_id_i, rd: bus.ex_rd_i,
                                      rs1: bus.ex_rs1_i, result: bus.ex_result_i};
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)
                count_q <= count_q + 1'b1;
            else if (pop && !push)
                count_q <= count_q - 1'b1;

            // Stray or mismatched strobes are flagged and otherwise ignored.
            if (bus.mem_result_valid_i && !mem_match)
                err_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (not_empty && ((head.instr == I_LW) || (head.instr == I_SW)))
                        state_q <= WAIT_MEM;
                end
                WAIT_MEM: begin
                    if (bypass) begin
                        state_q <= IDLE;
                    end else if (mem_match) begin
                        state_q     <= RESULT;
                        res_valid_q <= 1'b1;
                        res_id_q    <= head.id;
                        res_data_q  <= head.result;
                        res_rd_q    <= head.rs1;
                    end
                end
                RESULT: begin
                    if (bus.result_ready_i) begin
                        state_q     <= IDLE;
                        res_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/fir_xifu_wb_ctrl.md
Name: fir_xifu_wb_ctrl

Overview:
In-order writeback scheduler for the FIR XIFU. It sits between the EX stage and the writeback/regfile.
- Buffers up to DEPTH issued instructions.
- Matches XFIRLW/XFIRSW entries to their memory results.
- Drives the single FIR-regfile write port.
- Sequences the base-address autoincrement result onto the XIF result channel with full valid/ready backpressure.

Parameters:
DEPTH, 4, outstanding entry count (power of 2, >=2)
ID_W, 4, XIF instruction id width
RD_W, 2, FIR internal regfile address width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
ex_valid_i  in  1  EX offers an entry
ex_ready_o  out  1  entry accepted when valid&ready
ex_instr_i  in  2  0=XFIRDOTP, 1=XFIRLW, 2=XFIRSW, 3=NONE
ex_id_i  in  ID_W  XIF id
ex_rd_i  in  RD_W  FIR destination register
ex_rs1_i  in  5  GPR holding base address
ex_result_i  in  32  DOTP result or incremented address
mem_result_valid_i  in  1  memory result strobe
mem_result_id_i  in  ID_W  memory result id
mem_result_rdata_i  in  32  load data
result_valid_o  out  1  XIF result valid
result_ready_i  in  1  XIF result ready
result_id_o  out  ID_W  result id
result_data_o  out  32  autoincremented address
result_rd_o  out  5  = rs1 of entry
result_we_o  out  1  always 1 while result_valid_o
rf_we_o  out  1  FIR regfile write enable
rf_waddr_o  out  RD_W  write address
rf_wdata_o  out  32  write data
count_o  out  $clog2(DEPTH)+1  occupancy
err_o  out  1  sticky protocol error

Behaviour:
- Reset: clock clk_i; reset rst_i is synchronous and active-high.
  - FIFO emptied, FSM to IDLE, err_o=0.
  - All outputs 0, except ex_ready_o=1 after reset release.
  - Reset mid-operation discards all entries and any pending result.
- FIFO:
  - ex_ready_o = (count_o < DEPTH); no pop-through when full.
  - Push and pop in the same cycle leaves count unchanged.
  - Pointers wrap modulo DEPTH.
  - NONE entries are accepted and popped after 1 cycle at head, with no side effects.
- Head FSM (IDLE, WAIT_MEM, RESULT):
  - IDLE, FIFO non-empty, head DOTP: rf_we_o=1, rf_waddr_o=rd, rf_wdata_o=result that cycle; pop; stay IDLE. DOTP issues no XIF result.
  - IDLE, head LW/SW: -> WAIT_MEM the next cycle.
  - WAIT_MEM, mem_result_valid_i and id==head id:
    - LW: rf write of mem_result_rdata_i in this same cycle.
    - Latch result fields; -> RESULT.
  - RESULT: result_valid_o=1 with id, data=ex_result, rd=rs1, we=1. Outputs held stable until result_ready_i; on handshake pop, -> IDLE.
- DOTP entries never overtake LW/SW entries: strict program order.
- Each entry takes at least 1 cycle at head; a DOTP following a RESULT pop is written 1 cycle later.
- Errors:
  - mem_result_valid_i with id mismatch, or while not in WAIT_MEM: err_o set (sticky until reset), strobe ignored.
  - ex_valid_i while full is not an error; the entry is simply held by EX.
- Latency: mem result to result_valid_o = 1 cycle (registered).

Optional Feature:
FIR_XIFU_WB_BYPASS_EN:
- Defined: in WAIT_MEM, a matching mem result with result_ready_i=1 drives result_valid_o combinationally in the same cycle. The entry pops immediately, skipping RESULT; latency 0.
  - If result_ready_i=0, falls back to RESULT.
- Undefined: always registered via RESULT.

Test Plan:
- DOTP id=1 rd=2 result=0x0000_1234 on empty FIFO -> rf_we_o=1 next cycle with waddr=2, wdata=0x1234; no result_valid_o; count returns to 0.
- LW id=3 rs1=10 result=0x1004, mem id=3 rdata=0xDEAD_BEEF 2 cycles later, ready=1 -> rf write of 0xDEADBEEF that cycle; result_valid_o next cycle with id=3, data=0x1004, rd=10; count 0.
- SW id=5 with result_ready_i held low 5 cycles -> result_valid_o and fields stable for 6 cycles, pop on cycle ready=1; no rf write.
- Push 4 LWs, no mem results -> ex_ready_o=0, count_o=4. Return ids in order with ready=1 -> 4 results in order, pointers wrap, ex_ready_o=1.
- LW id=2 at head, mem id=7 strobe -> err_o=1 and sticky; entry still waits. Mem id=2 completes it. rst_i pulse -> err_o=0, count_o=0.
- With FIR_XIFU_WB_BYPASS_EN, LW matched with ready=1 -> result_valid_o in same cycle as mem_result_valid_i. Without the macro -> 1 cycle later.
